// File: rtl/d_cs_chien_search_core_pkg.sv
// -----------------------------------------------------------------------------
// d_cs_chien_search_core_pkg
// Shared constants, types and GF(2^12) helpers for the Chien search core.
//   - D_CS_GF_ORDER     : field width (12)
//   - D_CS_PRIM_POLY    : x^12+x^6+x^4+x+1 with the x^12 term folded away
//   - D_CS_ALPHA        : primitive element alpha = 12'h002
//   - state_t           : FSM encoding (IDLE / SEARCH / DONE)
//   - gf_alpha_pow(e)   : alpha^e, evaluated at elaboration to build the
//                         constant multiplier columns (the alpha-power table)
// -----------------------------------------------------------------------------
package d_cs_chien_search_core_pkg;

  localparam int D_CS_GF_ORDER = 12;
  localparam int D_CS_GF_SIZE  = 1 << D_CS_GF_ORDER;  // 4096
  localparam int D_CS_GF_NZ    = D_CS_GF_SIZE - 1;    // multiplicative group order

  typedef logic [D_CS_GF_ORDER-1:0] gf_t;

  localparam gf_t D_CS_PRIM_POLY = 12'h053;
  localparam gf_t D_CS_ALPHA     = 12'h002;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // One multiply-by-alpha step: shift left, fold the overflow bit back in.
  function automatic gf_t gf_mul_alpha(gf_t a);
    return {a[D_CS_GF_ORDER-2:0], 1'b0} ^ (a[D_CS_GF_ORDER-1] ? D_CS_PRIM_POLY : '0);
  endfunction

  // General shift-and-add field multiply (only used for constant folding).
  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t acc = '0;
    gf_t sh  = a;
    for (int i = 0; i < D_CS_GF_ORDER; i++) begin
      if (b[i]) acc ^= sh;
      sh = gf_mul_alpha(sh);
    end
    return acc;
  endfunction

  // alpha^e by square-and-multiply; e is reduced modulo the group order.
  function automatic gf_t gf_alpha_pow(int unsigned e);
    gf_t         result = 12'h001;
    gf_t         base   = D_CS_ALPHA;
    int unsigned ex     = e % D_CS_GF_NZ;
    for (int i = 0; i < D_CS_GF_ORDER; i++) begin
      if (ex[i]) result = gf_mul(result, base);
      base = gf_mul(base, base);
    end
    return result;
  endfunction

endpackage

// File: rtl/d_cs_chien_search_core_if.sv
// -----------------------------------------------------------------------------
// d_cs_chien_search_core_if
// Locator-in / error-positions-out bundle of the Chien search core.
//   master : upstream KES + downstream correction side (drives the locator)
//   slave  : the Chien search core
// Signals:
//   i_sigma_valid / o_sigma_ready : locator handshake
//   i_sigma      : (T+1) coefficients, sigma_k at [12k+11:12k]
//   i_sigma_deg  : locator degree 0..T
//   o_err_valid / o_err_pos       : one pulse per root, bit position
//   o_done / o_err_cnt / o_fail   : end-of-search summary
// -----------------------------------------------------------------------------
interface d_cs_chien_search_core_if
  import d_cs_chien_search_core_pkg::*;
#(
  parameter int T = 14
);
  logic                             i_sigma_valid;
  logic                             o_sigma_ready;
  logic [(T+1)*D_CS_GF_ORDER-1:0]   i_sigma;
  logic [3:0]                       i_sigma_deg;
  logic                             o_err_valid;
  gf_t                              o_err_pos;
  logic                             o_done;
  logic [3:0]                       o_err_cnt;
  logic                             o_fail;

  modport master (
    output i_sigma_valid, i_sigma, i_sigma_deg,
    input  o_sigma_ready, o_err_valid, o_err_pos, o_done, o_err_cnt, o_fail
  );

  modport slave (
    input  i_sigma_valid, i_sigma, i_sigma_deg,
    output o_sigma_ready, o_err_valid, o_err_pos, o_done, o_err_cnt, o_fail
  );
endinterface

// File: rtl/d_cs_chien_search_core_const_mult.sv
// -----------------------------------------------------------------------------
// d_cs_chien_search_core_const_mult
// Multiply a GF(2^12) element by the fixed constant alpha^E.
//   din  : field element
//   dout : din * alpha^E
// Multiplication by a constant is linear over GF(2): column j of the map is
// alpha^(E+j), i.e. the result of pushing bit j through E multiply-by-alpha
// steps. The columns fold to constants, leaving a plain XOR network.
// -----------------------------------------------------------------------------
module d_cs_chien_search_core_const_mult
  import d_cs_chien_search_core_pkg::*;
#(
  parameter int unsigned E = 1
) (
  input  gf_t din,
  output gf_t dout
);

  gf_t term [D_CS_GF_ORDER];

  for (genvar j = 0; j < D_CS_GF_ORDER; j++) begin : g_col
    localparam gf_t COL = gf_alpha_pow(E + j);
    assign term[j] = din[j] ? COL : '0;
  end

  always_comb begin
    // NOTE: assign a default before accumulating so no path leaves dout unassigned (no latch).
    dout = '0;
    for (int j = 0; j < D_CS_GF_ORDER; j++) dout ^= term[j];
  end

endmodule

// File: rtl/d_cs_chien_search_core.sv
// -----------------------------------------------------------------------------
// d_cs_chien_search_core
// Serial Chien search over a shortened GF(2^12) BCH codeword.
// Accepts an error-locator polynomial, evaluates it at alpha^(4096-N+s) for
// s = 0..N-1 (one point per cycle) and pulses the bit position N-1-s of every
// root, highest position first. Finishes with root count and a fail flag
// (count != latched degree).
// Ports:
//   i_clk, i_nRESET (async, active low), i_stop_dec (sync abort, priority)
//   cs : d_cs_chien_search_core_if.slave (locator handshake and results)
// Parameters: T (correction capability), N (shortened length, 1..4095)
// Build option: define D_CS_EARLY_TERM_EN to stop the sweep as soon as the
// root count reaches the degree (degree 0 finishes without sweeping).
// -----------------------------------------------------------------------------
module d_cs_chien_search_core
  import d_cs_chien_search_core_pkg::*;
#(
  parameter int T = 14,
  parameter int N = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_nRESET,
  input  logic                     i_stop_dec,
  d_cs_chien_search_core_if.slave  cs
);

  // Skipping the unused 4096-N leading positions of the full-length code.
  localparam int unsigned LOAD_SHIFT = D_CS_GF_SIZE - N;
  localparam logic [11:0] LAST_STEP  = 12'(N - 1);

  state_t      state_q, state_d;

  gf_t         r_q    [T+1];
  gf_t         r_load [T+1];
  gf_t         r_step [T+1];
  logic [11:0] s_q;
  logic [3:0]  cnt_q;
  logic [3:0]  deg_q;
  logic [3:0]  cnt_next;

  gf_t         sum;
  logic        in_search;
  logic        accept;
  logic        root;
  logic        finish;

  logic        err_valid_q, err_valid_d;
  gf_t         err_pos_q,   err_pos_d;
  logic        done_q,      done_d;
  logic [3:0]  err_cnt_q,   err_cnt_d;
  logic        fail_q,      fail_d;

  // ---------------------------------------------------------------------------
  // Constant multipliers: load pre-multiply by alpha^(k*(4096-N)) and the
  // per-step update by alpha^k.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k <= T; k++) begin : g_term
    d_cs_chien_search_core_const_mult #(.E(k * LOAD_SHIFT)) u_load (
      .din  (cs.i_sigma[D_CS_GF_ORDER*k +: D_CS_GF_ORDER]),
      .dout (r_load[k])
    );
    d_cs_chien_search_core_const_mult #(.E(k)) u_step (
      .din  (r_q[k]),
      .dout (r_step[k])
    );
  end

  // sigma evaluated at the current point.
  always_comb begin
    sum = '0;
    for (int k = 0; k <= T; k++) sum ^= r_q[k];
  end

  assign in_search = (state_q == ST_SEARCH);
  assign accept    = (state_q == ST_IDLE) && cs.i_sigma_valid && !i_stop_dec;
  assign cnt_next  = !root              ? cnt_q :
                     (cnt_q == 4'hF)    ? cnt_q : cnt_q + 4'd1;

`ifdef D_CS_EARLY_TERM_EN
  logic skip_search;
  assign skip_search = in_search && (deg_q == 4'd0);
  assign root        = in_search && !skip_search && (sum == '0);
  assign finish      = in_search &&
                       (skip_search || (s_q == LAST_STEP) || (root && (cnt_next == deg_q)));
`else
  assign root   = in_search && (sum == '0);
  assign finish = in_search && (s_q == LAST_STEP);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_nRESET) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM: next state (abort overrides everything)
  always_comb begin
    state_d = state_q;
    if (i_stop_dec) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (accept) state_d = ST_SEARCH;
        ST_SEARCH: if (finish) state_d = ST_DONE;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs (next values of the registered result outputs)
  always_comb begin
    err_valid_d = 1'b0;
    done_d      = 1'b0;
    err_pos_d   = err_pos_q;
    err_cnt_d   = err_cnt_q;
    fail_d      = fail_q;
    if (!i_stop_dec) begin
      if (root) begin
        err_valid_d = 1'b1;
        err_pos_d   = LAST_STEP - s_q;
      end
      // Same edge as a final root, so cnt_next already includes it.
      if (finish) begin
        done_d    = 1'b1;
        err_cnt_d = cnt_next;
        fail_d    = (cnt_next != deg_q);
      end
    end
  end

  assign cs.o_sigma_ready = (state_q == ST_IDLE);

  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      err_valid_q <= 1'b0;
      err_pos_q   <= '0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_q      <= 1'b0;
    end else begin
      err_valid_q <= err_valid_d;
      err_pos_q   <= err_pos_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      fail_q      <= fail_d;
    end
  end

  assign cs.o_err_valid = err_valid_q;
  assign cs.o_err_pos   = err_pos_q;
  assign cs.o_done      = done_q;
  assign cs.o_err_cnt   = err_cnt_q;
  assign cs.o_fail      = fail_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: the evaluation registers are always loaded before they are read, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (accept)         r_q <= r_load;
    else if (in_search) r_q <= r_step;
  end

  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      s_q   <= '0;
      cnt_q <= '0;
      deg_q <= '0;
    end else if (accept) begin
      s_q   <= '0;
      cnt_q <= '0;
      deg_q <= cs.i_sigma_deg;
    end else if (in_search) begin
      s_q   <= s_q + 12'd1;
      cnt_q <= cnt_next;
    end
  end

endmodule
